// File: rtl/mem_port_arbiter.sv
// Memory request port arbiter: shares one memory-controller port among
// NUM_REQ requesters, one outstanding transaction at a time.
module mem_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_resp_valid,
    input  logic [DATA_W-1:0]          mem_resp_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int SW  = $clog2(MAX_STREAK + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       streak_q, streak_d;
    logic [IDW-1:0]      rr_q, rr_d;
    logic [IDW-1:0]      grant_q, grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic                other_v;
    logic                win_ok;
    logic [IDW-1:0]      win;

    // Winner: requester 0 unless its streak is exhausted, else round-robin over 1..N-1
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_ok  = 1'b0;
        other_v = |req_valid[NUM_REQ-1:1];
        if (req_valid[0] && ((int'(streak_q) < MAX_STREAK) || !other_v)) begin
            win_ok = 1'b1;
        end else begin
            for (int k = 1; k < NUM_REQ; k++) begin
                idx = ((int'(rr_q) - 1 + k) % (NUM_REQ - 1)) + 1;
                if (!win_ok && req_valid[idx]) begin
                    win_ok = 1'b1;
                    win    = IDW'(idx);
                end
            end
        end
    end

    // Accept strobe only in IDLE, and never while reset is held
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && win_ok && !res) begin
            req_ready = NUM_REQ'(1) << win;
        end
    end

    // Next-state, latch and response logic
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            IDLE: begin
                if (win_ok) begin
                    state_d = ISSUE;
                    grant_d = win;
                    we_d    = req_we[win];
                    addr_d  = req_addr[int'(win)*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[int'(win)*DATA_W +: DATA_W];
                    if (win == '0) begin
                        if (!other_v) begin
                            streak_d = '0;
                        end else if (streak_q != SW'(MAX_STREAK)) begin
                            streak_d = streak_q + SW'(1);
                        end
                    end else begin
                        streak_d = '0;
                        rr_d     = win;
                    end
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_d     = IDLE;
                    rsp_valid_d = NUM_REQ'(1) << grant_q;
                    rsp_data_d  = mem_resp_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            rr_q        <= IDW'(NUM_REQ - 1);
            grant_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign mem_valid = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign grant_id  = grant_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
